// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC generation, credit-limited imem
// requests, in-order response capture into a show-ahead FIFO, and discard of
// responses that were already in flight when a redirect happened.
module fetch_unit #(
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        do_flush,
  input  logic [31:0] redirect_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = CW + OW;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [OW-1:0] r_outstanding;
  logic [OW-1:0] r_drop_cnt;
  logic [31:0]   r_mem_data [FIFO_DEPTH];
  logic [31:0]   r_mem_pc   [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_out_ok;
  logic          w_credit_ok;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_resp;
  logic          w_push;
  logic          w_pop;
  logic [OW-1:0] w_out_next;
  logic [SW-1:0] w_credit_sum;

  // Request credit: bounded in-flight count and room reserved in the FIFO
  // for every request already issued, so responses can never overflow it.
  always_comb begin
    w_credit_sum = SW'(r_count) + SW'(r_outstanding);
    w_out_ok     = (r_outstanding < OW'(MAX_OUTSTANDING));
    w_credit_ok  = (w_credit_sum < SW'(FIFO_DEPTH));
    // valid never looks at ready; reset gating keeps the channel quiet while held
    w_req_valid  = !reset && !do_flush && w_out_ok && w_credit_ok;
    w_accept     = w_req_valid && imem_req_ready;
    // a response with nothing outstanding is a stray and is ignored
    w_resp       = imem_resp_valid && (r_outstanding != '0);
    w_push       = w_resp && !do_flush && (r_drop_cnt == '0);
    w_pop        = (r_count != '0) && !stall && !do_flush;
    w_out_next   = r_outstanding + OW'(w_accept) - OW'(w_resp);
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign instr_valid    = (r_count != '0);
  assign instr          = r_mem_data[r_rd_ptr];
  assign instr_pc       = r_mem_pc[r_rd_ptr];

  // PC tracking, in-flight accounting and drop counter; flush wins over all.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (do_flush) begin
        r_fetch_pc <= redirect_addr;
        r_resp_pc  <= redirect_addr;
        // everything still in flight after this edge belongs to the old path
        r_drop_cnt <= w_out_next;
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + 32'd4;
        end
        if (w_resp && (r_drop_cnt != '0)) begin
          r_drop_cnt <= r_drop_cnt - OW'(1);
        end
      end
    end
  end

  // Instruction buffer: show-ahead FIFO of {instruction, pc}.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= 32'h0000_0000;
        r_mem_pc[i]   <= 32'h0000_0000;
      end
    end else if (do_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= imem_resp_data;
        r_mem_pc[r_wr_ptr]   <= r_resp_pc;
        r_wr_ptr             <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end else begin
        r_count <= r_count;
      end
    end
  end

endmodule
